sha_word_loader: RTL and testbench

- Upstream feeder for the SHA-256 engine inside the minimum security module.
- Accepts a pre-padded message as a stream of 32-bit words over a valid/ready handshake and packs each group of 16 words into a 512-bit block.
- Sequences init/next pulses into the SHA engine, captures the final digest, and compares it against an expected digest, producing a pass/fail result for boot control.

---
 rtl/sha_loader_pkg.sv | 17 +
 rtl/sha_block_packer.sv | 47 ++++
 rtl/sha_word_loader.sv | 145 ++++++++++++++
 tb/tb_sha_word_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_loader_pkg.sv
// Shared types and constants for the SHA-256 word loader and its block packer.
package sha_loader_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int BLOCK_W         = 512;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    WAIT_DIG,
    DONE
  } state_t;

endpackage

// File: rtl/sha_block_packer.sv
// Word-index counter and 512-bit packing register. Accepted words land
// big-endian: word 0 occupies the top 32 bits of the block, word 15 the bottom.
module sha_block_packer
  import sha_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [WORD_W-1:0]  word,
  output logic [BLOCK_W-1:0] block,
  output logic               at_last
);

  logic [WORD_IDX_W-1:0] idx;

  assign at_last = (idx == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

  // Word index: cleared outside FILL, advances on every accepted word and
  // wraps back to 0 after the sixteenth word of a block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (load) begin
      idx <= idx + 1'b1;
    end
  end

  // Block register: only the slot selected by the current index is written,
  // so the block stays stable whenever no word is being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block <= '0;
    end else if (load) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        if (idx == WORD_IDX_W'(i)) begin
          block[BLOCK_W-1-WORD_W*i -: WORD_W] <= word;
        end
      end
    end
  end

endmodule

// File: rtl/sha_word_loader.sv
// Upstream feeder for the SHA-256 engine: packs a pre-padded word stream into
// 512-bit blocks, sequences init/next pulses, captures the final digest and
// compares it with the expected digest to give boot control a pass/fail.
module sha_word_loader
  import sha_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int MAX_BLOCKS = 64,
  parameter int BLK_CNT_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [255:0]       exp_digest,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_last,
  output logic [BLOCK_W-1:0] sha_block,
  output logic               sha_init,
  output logic               sha_next,
  input  logic               sha_ready,
  input  logic [255:0]       sha_digest,
  input  logic               sha_digest_valid,
  output logic [255:0]       digest,
  output logic               done,
  output logic               match,
  output logic               err,
  output logic               busy
);

  localparam logic [BLK_CNT_W-1:0] MAX_CNT = BLK_CNT_W'(MAX_BLOCKS);

  state_t               state;
  logic [255:0]         exp_q;
  logic [BLK_CNT_W-1:0] blk_cnt;
  logic                 last_blk;
  logic                 skip;
  logic                 accept;
  logic                 at_last;
  logic                 clear_idx;

  assign in_ready  = (state == FILL);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign clear_idx = (state != FILL);

  sha_block_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_idx),
    .load    (accept),
    .word    (in_word),
    .block   (sha_block),
    .at_last (at_last)
  );

  // Main sequencer: fills blocks, hands them to the engine one pulse at a
  // time, waits out the engine, then captures and judges the final digest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      exp_q    <= '0;
      digest   <= '0;
      match    <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      sha_init <= 1'b0;
      sha_next <= 1'b0;
      blk_cnt  <= '0;
      last_blk <= 1'b0;
      skip     <= 1'b0;
    end else begin
      done     <= 1'b0;
      sha_init <= 1'b0;
      sha_next <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_q    <= exp_digest;
            err      <= 1'b0;
            match    <= 1'b0;
            blk_cnt  <= '0;
            last_blk <= 1'b0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (at_last) begin
              last_blk <= in_last;
              state    <= ISSUE;
            end else if (in_last) begin
              err   <= 1'b1;
              match <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (blk_cnt == MAX_CNT) begin
            err   <= 1'b1;
            match <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (sha_ready) begin
            if (blk_cnt == '0) begin
              sha_init <= 1'b1;
            end else begin
              sha_next <= 1'b1;
            end
            blk_cnt <= blk_cnt + 1'b1;
            skip    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (sha_ready) begin
            state <= last_blk ? WAIT_DIG : FILL;
          end
        end
        WAIT_DIG: begin
          if (sha_digest_valid) begin
            digest <= sha_digest;
            match  <= (sha_digest == exp_q);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_word_loader.sv
// Self-checking bench for sha_word_loader with a behavioural SHA-256 engine.
module tb_sha_word_loader;

  localparam int MAX_BLK = 64;

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] NIST_D =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] NIST_W [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] exp_digest;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         in_last;
  logic [511:0] sha_block;
  logic         sha_init;
  logic         sha_next;
  logic         sha_ready;
  logic [255:0] sha_digest;
  logic         sha_digest_valid;
  logic [255:0] digest;
  logic         done;
  logic         match;
  logic         err;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0]  msg [$];
  logic [255:0] model_digest = '0;

  always #5 clk = ~clk;

  sha_word_loader dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .exp_digest       (exp_digest),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_word          (in_word),
    .in_last          (in_last),
    .sha_block        (sha_block),
    .sha_init         (sha_init),
    .sha_next         (sha_next),
    .sha_ready        (sha_ready),
    .sha_digest       (sha_digest),
    .sha_digest_valid (sha_digest_valid),
    .digest           (digest),
    .done             (done),
    .match            (match),
    .err              (err),
    .busy             (busy)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression round set over a 512-bit block.
  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Digest of every complete 16-word block of the current message.
  function automatic logic [255:0] model_hash();
    logic [255:0] h;
    logic [511:0] blk;
    h = SHA_IV;
    for (int bi = 0; bi < msg.size() / 16; bi++) begin
      for (int k = 0; k < 16; k++) blk[511-32*k -: 32] = msg[16*bi+k];
      h = sha_compress(h, blk);
    end
    return h;
  endfunction

  // Behavioural SHA engine: samples the block on a pulse, drops ready one
  // cycle later, and returns ready with a valid digest after a random delay.
  logic [255:0] eng_h;
  logic         eng_rdy;
  int           eng_cnt;
  logic         hold = 1'b0;
  assign sha_ready = eng_rdy && !hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_rdy          <= 1'b1;
      eng_h            <= '0;
      eng_cnt          <= 0;
      sha_digest       <= '0;
      sha_digest_valid <= 1'b0;
    end else if (sha_init || sha_next) begin
      eng_h            <= sha_compress(sha_init ? SHA_IV : eng_h, sha_block);
      eng_rdy          <= 1'b0;
      sha_digest_valid <= 1'b0;
      eng_cnt          <= int'($urandom_range(12, 3));
    end else if (!eng_rdy) begin
      if (eng_cnt <= 1) begin
        eng_rdy          <= 1'b1;
        sha_digest_valid <= 1'b1;
        sha_digest       <= eng_h;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Protocol watcher: pulse counts and handshake-rule violations.
  int   mon_init = 0;
  int   mon_next = 0;
  int   mon_viol = 0;
  logic prev_pulse = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    prev_pulse <= sha_init | sha_next;
    prev_done  <= done;
    if (sha_init) mon_init <= mon_init + 1;
    if (sha_next) mon_next <= mon_next + 1;
    if ((sha_init && sha_next) || ((sha_init || sha_next) && (prev_pulse || !sha_ready)) ||
        (in_ready && !busy) || (done && prev_done))
      mon_viol <= mon_viol + 1;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one message from msg through the loader and checks the outcome
  // against expectations derived from the message length and SHA-256.
  task automatic applyStimulus(input string name, input logic [255:0] expd, input int gap_pct,
                               input bit stall, input bit poke);
    int n, fb, e_pulses, e_init, i, cyc, base_init, base_next, base_viol;
    logic [255:0] e_dig;
    bit e_err, e_match, acc;
    n  = msg.size();
    fb = n / 16;
    if (n % 16 != 0) begin
      e_err = 1; e_match = 0; e_dig = model_digest;
      e_pulses = (fb > MAX_BLK) ? MAX_BLK : fb;
    end else if (fb > MAX_BLK) begin
      e_err = 1; e_match = 0; e_dig = model_digest; e_pulses = MAX_BLK;
    end else begin
      e_dig = model_hash(); e_err = 0; e_match = (e_dig == expd); e_pulses = fb;
    end
    e_init = (e_pulses > 0) ? 1 : 0;
    base_init = mon_init; base_next = mon_next; base_viol = mon_viol;
    hold = stall;
    @(negedge clk);
    start = 1'b1; exp_digest = expd;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, ":busy"}, 256'(busy), 256'(1));
    i = 0; cyc = 0;
    while (i < n && cyc < 40000) begin
      start = poke && (i == 3);
      if (poke && i == 3) exp_digest = ~expd;
      in_valid = ($urandom_range(99, 0) >= gap_pct);
      in_word  = msg[i];
      in_last  = (i == n - 1);
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checkOutput({name, ":fed"}, 256'(i), 256'(n));
    if (stall) begin
      repeat (20) @(negedge clk);
      checkOutput({name, ":stall_pulses"}, 256'(mon_init + mon_next - base_init - base_next), 256'(0));
      hold = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, ":done"}, 256'(done), 256'(1));
    checkOutput({name, ":err"}, 256'(err), 256'(e_err));
    checkOutput({name, ":match"}, 256'(match), 256'(e_match));
    checkOutput({name, ":digest"}, digest, e_dig);
    checkOutput({name, ":init_pulses"}, 256'(mon_init - base_init), 256'(e_init));
    checkOutput({name, ":next_pulses"}, 256'(mon_next - base_next), 256'(e_pulses - e_init));
    @(negedge clk);
    checkOutput({name, ":done_width"}, 256'(done), 256'(0));
    checkOutput({name, ":idle"}, 256'(busy), 256'(0));
    checkOutput({name, ":protocol"}, 256'(mon_viol - base_viol), 256'(0));
    if (!e_err) model_digest = e_dig;
  endtask

  task automatic loadAbc();
    msg.delete();
    msg.push_back(32'h61626380);
    repeat (14) msg.push_back(32'h0);
    msg.push_back(32'h00000018);
  endtask

  task automatic loadNist();
    msg.delete();
    for (int k = 0; k < 14; k++) msg.push_back(NIST_W[k]);
    msg.push_back(32'h80000000);
    repeat (16) msg.push_back(32'h0);
    msg.push_back(32'h000001c0);
  endtask

  initial begin
    int i, cyc;
    bit acc;
    logic [255:0] rnd;
    rst = 1'b1; start = 1'b0; exp_digest = '0; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset:ctrl", 256'({in_ready, busy, done, match, err, sha_init, sha_next}), 256'(0));
    checkOutput("reset:digest", digest, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    loadAbc();
    applyStimulus("abc", ABC_D, 0, 1'b0, 1'b0);
    loadNist();
    applyStimulus("nist2", NIST_D, 0, 1'b0, 1'b0);
    loadAbc();
    applyStimulus("abc_wrong_exp", ABC_D ^ 256'd1, 0, 1'b0, 1'b0);
    loadAbc();
    while (msg.size() > 6) void'(msg.pop_back());
    applyStimulus("early_last", ABC_D, 0, 1'b0, 1'b0);
    loadAbc();
    applyStimulus("abc_bubbles", ABC_D, 40, 1'b1, 1'b0);

    loadNist();
    @(negedge clk);
    start = 1'b1; exp_digest = NIST_D;
    @(negedge clk);
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < 24 && cyc < 2000) begin
      in_valid = 1'b1; in_word = msg[i]; in_last = 1'b0;
      acc = in_ready;
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    checkOutput("midrst:fed", 256'(i), 256'(24));
    checkOutput("midrst:block_loaded", 256'(sha_block != '0), 256'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst:ctrl", 256'({in_ready, busy, done, match, err, sha_init, sha_next}), 256'(0));
    checkOutput("midrst:block", 256'(sha_block == '0), 256'(1));
    checkOutput("midrst:digest", digest, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    model_digest = '0;
    loadAbc();
    applyStimulus("abc_after_rst", ABC_D, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      msg.delete();
      repeat (16 * $urandom_range(3, 1)) msg.push_back($urandom);
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus($sformatf("rand%0d", r), ($urandom_range(1, 0) == 1) ? model_hash() : rnd,
                    int'($urandom_range(50, 0)), 1'b0, 1'b1);
    end

    msg.delete();
    repeat (16 * (MAX_BLK + 1)) msg.push_back($urandom);
    applyStimulus("overflow", SHA_IV, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
